// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM generator slice.
package pwm_pkg;

    typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} pwm_state_t;

    localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/pwm_duty_shadow.sv
// Double-buffered duty: valid/ready capture into pending, swap to active at cnt==0.
// eff_duty is combinational; duty_ready stays low from capture until the next boundary swap.
module pwm_duty_shadow
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic [CNT_W:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic [CNT_W:0]   eff_duty
);

    localparam logic [CNT_W:0] DUTY_MAX = {1'b1, {CNT_W{1'b0}}};

    logic [CNT_W:0] active_q, active_d;
    logic [CNT_W:0] pending_q, pending_d;
    logic           pending_full_q, pending_full_d;
    logic [CNT_W:0] duty_clamped;
    logic           xfer;

    assign duty_ready   = !pending_full_q && !rst;
    assign xfer         = duty_valid && duty_ready;
    assign duty_clamped = (duty_in > DUTY_MAX) ? DUTY_MAX : duty_in;
    assign eff_duty     = (boundary && pending_full_q) ? pending_q : active_q;

    always_comb begin
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        if (boundary && pending_full_q) begin
            active_d       = pending_q;
            pending_full_d = 1'b0;
        end
        // Ready is low while full, so a transfer never collides with the swap above.
        if (xfer) begin
            pending_d      = duty_clamped;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
        end else begin
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// Period-aligned PWM from an upstream free-running count; pwm_out registered, 1 clk latency.
// Optional completed-period counter under PWM_PERIOD_CNT_EN.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
`ifdef PWM_PERIOD_CNT_EN
    ,
    parameter int PC_W  = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    input  logic [CNT_W:0]   duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             busy
`ifdef PWM_PERIOD_CNT_EN
    ,
    output logic [PC_W-1:0]  period_count
`endif
);

    pwm_state_t     state_q, state_d;
    logic           pwm_out_q, pwm_out_d;
    logic           period_start_q, period_start_d;
    logic           driving;
    logic           boundary;
    logic [CNT_W:0] eff_duty;

    assign boundary     = (cnt == '0);
    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign busy         = (state_q != IDLE);

    pwm_duty_shadow #(
        .CNT_W      (CNT_W)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .boundary   (boundary),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .eff_duty   (eff_duty)
    );

    always_comb begin
        state_d = state_q;
        driving = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) state_d = ARM;
            end
            ARM: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (boundary) begin
                    state_d = RUN;
                    driving = 1'b1;
                end
            end
            RUN: begin
                driving = 1'b1;
                if (!en) state_d = STOP;
            end
            STOP: begin
                // Finish the current period; only stop at the next boundary.
                if (en) begin
                    state_d = RUN;
                    driving = 1'b1;
                end else if (boundary) begin
                    state_d = IDLE;
                end else begin
                    driving = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        pwm_out_d      = driving && ({1'b0, cnt} < eff_duty);
        period_start_d = driving && boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

`ifdef PWM_PERIOD_CNT_EN
    logic            seen_start_q, seen_start_d;
    logic [PC_W-1:0] period_count_q, period_count_d;

    assign period_count = period_count_q;

    // The first start of a run opens a period; every later start closes one.
    always_comb begin
        seen_start_d   = seen_start_q;
        period_count_d = period_count_q;
        if (period_start_d) begin
            seen_start_d = 1'b1;
            if (seen_start_q && (period_count_q != '1)) begin
                period_count_d = period_count_q + PC_W'(1);
            end
        end
        if (state_d == IDLE) seen_start_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_start_q   <= 1'b0;
            period_count_q <= '0;
        end else begin
            seen_start_q   <= seen_start_d;
            period_count_q <= period_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen with a 4-bit up-counter model driving cnt.
module tb_pwm_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt;
    logic       en;
    logic [4:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_start;
    logic       busy;
`ifdef PWM_PERIOD_CNT_EN
    logic [7:0] period_count;
`endif

    int         total = 0;
    int         bad = 0;
    logic [3:0] prev_cnt;
    logic       cnt_hold;

    always #5 clk = ~clk;

    pwm_gen #(
        .CNT_W        (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cnt          (cnt),
        .en           (en),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .busy         (busy)
`ifdef PWM_PERIOD_CNT_EN
        ,
        .period_count (period_count)
`endif
    );

    // Outputs are looked at 1 time unit after the edge; prev_cnt is the count the edge consumed.
    task automatic tick();
        @(posedge clk);
        #1;
        prev_cnt = cnt;
        if (cnt_hold) cnt = 4'd0;
        else          cnt = cnt + 4'd1;
    endtask

    task automatic run_to(input logic [3:0] target);
        for (int i = 0; i < 40 && cnt != target; i++) tick();
    endtask

    task automatic send_duty(input logic [4:0] d);
        duty_in    = d;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; duty_valid = 1'b1; duty_in = 5'd9; cnt = 4'd0; cnt_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL rst_pwm got=%b want=0", pwm_out); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
            total++; if (period_start !== 1'b0) begin bad++; $display("FAIL rst_pstart got=%b want=0", period_start); end
            total++; if (duty_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_rst got=%b want=0", duty_ready); end
        end
        rst = 1'b0; duty_valid = 1'b0;
        #1;
        total++; if (duty_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", duty_ready); end
`ifdef PWM_PERIOD_CNT_EN
        total++; if (period_count !== 8'd0) begin bad++; $display("FAIL rst_pcount got=%0d want=0", period_count); end
`endif
    endtask

    task automatic test_duty5();
        logic e;
        int   highs = 0;
        run_to(4'd3);
        send_duty(5'd5);
        total++; if (duty_ready !== 1'b0) begin bad++; $display("FAIL d5_ready_full got=%b want=0", duty_ready); end
        run_to(4'd8);
        en = 1'b1;
        tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL d5_arm_busy got=%b want=1", busy); end
        run_to(4'd0);
        total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL d5_arm_pwm got=%b want=0", pwm_out); end
        for (int i = 0; i < 32; i++) begin
            tick();
            e = (prev_cnt < 4'd5);
            if (i < 16 && pwm_out === 1'b1) highs++;
            total++; if (pwm_out !== e) begin bad++; $display("FAIL d5_pwm cnt=%0d got=%b want=%b", prev_cnt, pwm_out, e); end
            total++; if (period_start !== (prev_cnt == 4'd0)) begin bad++; $display("FAIL d5_pstart cnt=%0d got=%b", prev_cnt, period_start); end
            total++; if (duty_ready !== 1'b1) begin bad++; $display("FAIL d5_ready cnt=%0d got=%b want=1", prev_cnt, duty_ready); end
        end
        total++; if (highs != 5) begin bad++; $display("FAIL d5_high_count got=%0d want=5", highs); end
    endtask

    task automatic test_duty_extremes();
        logic [4:0] dv [3];
        logic       ev [3];
        dv[0] = 5'd0;  ev[0] = 1'b0;
        dv[1] = 5'd16; ev[1] = 1'b1;
        dv[2] = 5'd20; ev[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            run_to(4'd4);
            send_duty(dv[k]);
            run_to(4'd0);
            for (int i = 0; i < 16; i++) begin
                tick();
                total++; if (pwm_out !== ev[k]) begin bad++; $display("FAIL ext_pwm duty=%0d cnt=%0d got=%b want=%b", dv[k], prev_cnt, pwm_out, ev[k]); end
                total++; if (period_start !== (i == 0)) begin bad++; $display("FAIL ext_pstart duty=%0d cnt=%0d got=%b", dv[k], prev_cnt, period_start); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        run_to(4'd4);
        send_duty(5'd8);
        run_to(4'd0);
        for (int i = 0; i < 16; i++) begin
            duty_valid = (cnt == 4'd7) || (cnt == 4'd10);
            duty_in    = (cnt == 4'd7) ? 5'd3 : 5'd12;
            tick();
            e = (prev_cnt < 4'd8);
            total++; if (pwm_out !== e) begin bad++; $display("FAIL b2b_pwm8 cnt=%0d got=%b want=%b", prev_cnt, pwm_out, e); end
            total++; if (duty_ready !== (prev_cnt < 4'd7)) begin bad++; $display("FAIL b2b_ready cnt=%0d got=%b", prev_cnt, duty_ready); end
        end
        duty_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            e = (prev_cnt < 4'd3);
            total++; if (pwm_out !== e) begin bad++; $display("FAIL b2b_pwm3 cnt=%0d got=%b want=%b", prev_cnt, pwm_out, e); end
            total++; if (duty_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after cnt=%0d got=%b want=1", prev_cnt, duty_ready); end
        end
    endtask

    task automatic test_stop_restart();
        logic e;
        run_to(4'd4);
        send_duty(5'd8);
        run_to(4'd0);
        for (int i = 0; i < 16; i++) begin
            if (cnt == 4'd2) en = 1'b0;
            tick();
            e = (prev_cnt < 4'd8);
            total++; if (pwm_out !== e) begin bad++; $display("FAIL stop_pwm cnt=%0d got=%b want=%b", prev_cnt, pwm_out, e); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_busy cnt=%0d got=%b want=1", prev_cnt, busy); end
        end
        tick();
        total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL stop_idle_pwm got=%b want=0", pwm_out); end
        total++; if (period_start !== 1'b0) begin bad++; $display("FAIL stop_idle_pstart got=%b want=0", period_start); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_idle_busy got=%b want=0", busy); end
        en = 1'b1;
        tick();
        run_to(4'd0);
        for (int i = 0; i < 32; i++) begin
            if (i == 2)  en = 1'b0;
            if (i == 10) en = 1'b1;
            tick();
            e = (prev_cnt < 4'd8);
            total++; if (pwm_out !== e) begin bad++; $display("FAIL restart_pwm i=%0d got=%b want=%b", i, pwm_out, e); end
            total++; if (period_start !== (prev_cnt == 4'd0)) begin bad++; $display("FAIL restart_pstart i=%0d got=%b", i, period_start); end
        end
    endtask

    task automatic test_rst_mid();
        run_to(4'd1);
        send_duty(5'd2);
        run_to(4'd4);
        rst = 1'b1;
        tick();
        total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL rmid_pwm got=%b want=0", pwm_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
        total++; if (duty_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready_in_rst got=%b want=0", duty_ready); end
        rst = 1'b0;
        #1;
        total++; if (duty_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_after got=%b want=1", duty_ready); end
`ifdef PWM_PERIOD_CNT_EN
        total++; if (period_count !== 8'd0) begin bad++; $display("FAIL rmid_pcount_clr got=%0d want=0", period_count); end
`endif
        run_to(4'd0);
        for (int i = 0; i < 48; i++) begin
            tick();
            total++; if (pwm_out !== 1'b0) begin bad++; $display("FAIL rmid_pwm_lost i=%0d got=%b want=0", i, pwm_out); end
            total++; if (period_start !== (prev_cnt == 4'd0)) begin bad++; $display("FAIL rmid_pstart i=%0d got=%b", i, period_start); end
        end
`ifdef PWM_PERIOD_CNT_EN
        total++; if (period_count !== 8'd2) begin bad++; $display("FAIL pcount_3per got=%0d want=2", period_count); end
`endif
    endtask

    task automatic test_cnt_hold();
        send_duty(5'd2);
        cnt_hold = 1'b1;
        cnt      = 4'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (pwm_out !== 1'b1) begin bad++; $display("FAIL hold_pwm i=%0d got=%b want=1", i, pwm_out); end
            total++; if (period_start !== 1'b1) begin bad++; $display("FAIL hold_pstart i=%0d got=%b want=1", i, period_start); end
        end
        cnt_hold = 1'b0;
        en       = 1'b0;
    endtask

    initial begin
        test_reset();
        test_duty5();
        test_duty_extremes();
        test_back_to_back();
        test_stop_restart();
        test_rst_mid();
        test_cnt_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
